// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 hardwired to zero, a per-register busy scoreboard and a sequential clear sweep.
// Define REGFILE_BYPASS_EN to forward in-flight writeback data and mask busy on the read ports.
module regfile_scoreboard #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [AW-1:0]   RS1_ADDR,
   input  logic [AW-1:0]   RS2_ADDR,
   output logic [XLEN-1:0] RS1_DATA,
   output logic [XLEN-1:0] RS2_DATA,
   output logic            RS1_BUSY,
   output logic            RS2_BUSY,
   input  logic            WB_EN,
   input  logic [AW-1:0]   WB_ADDR,
   input  logic [XLEN-1:0] WB_DATA,
   input  logic            ISSUE_EN,
   input  logic [AW-1:0]   ISSUE_RD,
   output logic            READY
);

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
   localparam logic [AW-1:0]   LAST_ADDR = AW'(NREGS - 1);
   localparam logic [AW-1:0]   ONE_ADDR  = AW'(1);
   localparam logic [XLEN-1:0] ZERO_DATA = {XLEN{1'b0}};

   state_t           state_r, state_s;
   logic [AW-1:0]    cnt_r, cnt_s;
   logic             ready_r, ready_s;
   logic [NREGS-1:0] busy_r, busy_s;
   logic [XLEN-1:0]  regs_r [NREGS];

   logic             run_s;
   logic             wb_ok_s;
   logic             issue_ok_s;
   logic             wr_en_s;
   logic [AW-1:0]    wr_addr_s;
   logic [XLEN-1:0]  wr_data_s;

   assign run_s      = (state_r == ST_RUN);
   assign wb_ok_s    = WB_EN && (WB_ADDR != ZERO_ADDR);
   assign issue_ok_s = ISSUE_EN && (ISSUE_RD != ZERO_ADDR);
   assign READY      = ready_r;

   // Control state: FSM, sweep counter, READY flag and busy scoreboard
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r <= ST_CLEAR;
         cnt_r   <= ZERO_ADDR;
         ready_r <= 1'b0;
         busy_r  <= {NREGS{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
      end
   end

   // Next-state logic and storage write selection
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      ready_s   = ready_r;
      busy_s    = busy_r;
      wr_en_s   = 1'b0;
      wr_addr_s = cnt_r;
      wr_data_s = ZERO_DATA;
      case (state_r)
         ST_CLEAR: begin
            wr_en_s = 1'b1;
            cnt_s   = cnt_r + ONE_ADDR;
            if (cnt_r == LAST_ADDR) begin
               state_s = ST_RUN;
               ready_s = 1'b1;
            end else begin
               state_s = ST_CLEAR;
               ready_s = 1'b0;
            end
         end
         ST_RUN: begin
            wr_en_s   = wb_ok_s;
            wr_addr_s = WB_ADDR;
            wr_data_s = WB_DATA;
            // Clear first, then set: a same-edge issue is the newer producer
            busy_s[WB_ADDR]  = busy_s[WB_ADDR] & ~wb_ok_s;
            busy_s[ISSUE_RD] = busy_s[ISSUE_RD] | issue_ok_s;
         end
         default: begin
            state_s = ST_CLEAR;
            cnt_s   = ZERO_ADDR;
            ready_s = 1'b0;
         end
      endcase
   end

   // Storage array has no reset of its own; the clear sweep zeroes it
   always_ff @(posedge CLK) begin
      if (wr_en_s && !RESET) begin
         regs_r[wr_addr_s] <= wr_data_s;
      end
   end

   // Combinational read ports; x0 and the sweep read as zero and not busy
   always_comb begin
      RS1_DATA = ZERO_DATA;
      RS1_BUSY = 1'b0;
      RS2_DATA = ZERO_DATA;
      RS2_BUSY = 1'b0;
      if (run_s && (RS1_ADDR != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
         if (WB_EN && (WB_ADDR == RS1_ADDR)) begin
            RS1_DATA = WB_DATA;
            RS1_BUSY = 1'b0;
         end else begin
            RS1_DATA = regs_r[RS1_ADDR];
            RS1_BUSY = busy_r[RS1_ADDR];
         end
`else
         RS1_DATA = regs_r[RS1_ADDR];
         RS1_BUSY = busy_r[RS1_ADDR];
`endif
      end else begin
         RS1_DATA = ZERO_DATA;
         RS1_BUSY = 1'b0;
      end
      if (run_s && (RS2_ADDR != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
         if (WB_EN && (WB_ADDR == RS2_ADDR)) begin
            RS2_DATA = WB_DATA;
            RS2_BUSY = 1'b0;
         end else begin
            RS2_DATA = regs_r[RS2_ADDR];
            RS2_BUSY = busy_r[RS2_ADDR];
         end
`else
         RS2_DATA = regs_r[RS2_ADDR];
         RS2_BUSY = busy_r[RS2_ADDR];
`endif
      end else begin
         RS2_DATA = ZERO_DATA;
         RS2_BUSY = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: behavioural model compared every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_regfile_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic [AW-1:0]   RS1_ADDR = '0;
   logic [AW-1:0]   RS2_ADDR = '0;
   logic [XLEN-1:0] RS1_DATA, RS2_DATA;
   logic            RS1_BUSY, RS2_BUSY;
   logic            WB_EN = 1'b0;
   logic [AW-1:0]   WB_ADDR = '0;
   logic [XLEN-1:0] WB_DATA = '0;
   logic            ISSUE_EN = 1'b0;
   logic [AW-1:0]   ISSUE_RD = '0;
   logic            READY;

   always #5 CLK = ~CLK;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .CLK(CLK), .RESET(RESET),
      .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
      .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
      .RS1_BUSY(RS1_BUSY), .RS2_BUSY(RS2_BUSY),
      .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD),
      .READY(READY)
   );

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   // Reference model: ready after NREGS reset-free edges, then architectural registers plus busy set
   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_busy = '0;
   int               m_edges = 0;
   logic             m_ready = 1'b0;

   always @(posedge CLK) begin
      if (RESET) begin
         m_ready <= 1'b0;
         m_edges <= 0;
         m_busy  <= '0;
      end else if (!m_ready) begin
         m_edges <= m_edges + 1;
         if (m_edges == NREGS - 1) begin
            m_ready <= 1'b1;
            for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
         end
      end else begin
         if (WB_EN && WB_ADDR != 0) m_regs[WB_ADDR] <= WB_DATA;
         m_busy <= (m_busy & ~((WB_EN && WB_ADDR != 0) ? (32'd1 << WB_ADDR) : 32'd0))
                   | ((ISSUE_EN && ISSUE_RD != 0) ? (32'd1 << ISSUE_RD) : 32'd0);
      end
   end

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
      if (!m_ready || a == 0) return '0;
      if (BYPASS && WB_EN && WB_ADDR == a) return WB_DATA;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (!m_ready || a == 0) return 1'b0;
      if (BYPASS && WB_EN && WB_ADDR == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("model_ready", {31'd0, READY}, {31'd0, m_ready});
         chk("model_rs1_data", RS1_DATA, exp_data(RS1_ADDR));
         chk("model_rs2_data", RS2_DATA, exp_data(RS2_ADDR));
         chk("model_rs1_busy", {31'd0, RS1_BUSY}, {31'd0, exp_busy(RS1_ADDR)});
         chk("model_rs2_busy", {31'd0, RS2_BUSY}, {31'd0, exp_busy(RS2_ADDR)});
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic print_regs();
      for (int i = 0; i < NREGS; i++)
         $display("x%0d = %h busy=%0b", i, dut.regs_r[i], dut.busy_r[i]);
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < NREGS; i++) begin
         tick();
         RS1_ADDR = AW'(i);
         RS2_ADDR = AW'(NREGS - 1 - i);
         @(negedge CLK);
         chk(name, RS1_DATA, 32'h0);
         chk(name, RS2_DATA, 32'h0);
      end
   endtask

   initial begin
      // 1. reset and sweep length
      tick();
      tick();
      chk_en = 1'b1;
      @(negedge CLK);
      chk("reset_ready", {31'd0, READY}, 32'd0);
      tick();
      RESET = 1'b0;
      repeat (31) @(posedge CLK);
      @(negedge CLK);
      chk("sweep_ready_31", {31'd0, READY}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      chk("sweep_ready_32", {31'd0, READY}, 32'd1);
      read_all_zero("sweep_zero");

      // 2. write then read, x0 write dropped
      tick(); WB_EN = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'hDEADBEEF;
      tick(); WB_EN = 1'b0; RS1_ADDR = 5'd5;
      @(negedge CLK); chk("wb_x5", RS1_DATA, 32'hDEADBEEF);
      tick(); WB_EN = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'h1234; RS2_ADDR = 5'd0;
      tick(); WB_EN = 1'b0;
      @(negedge CLK); chk("wb_x0", RS2_DATA, 32'h0);

      // 3. scoreboard
      tick(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd7;
      tick(); ISSUE_EN = 1'b0; RS1_ADDR = 5'd7;
      @(negedge CLK); chk("issue_x7_busy", {31'd0, RS1_BUSY}, 32'd1);
      tick(); WB_EN = 1'b1; WB_ADDR = 5'd7; WB_DATA = 32'h55;
      tick(); WB_EN = 1'b0;
      @(negedge CLK);
      chk("wb_x7_busy", {31'd0, RS1_BUSY}, 32'd0);
      chk("wb_x7_data", RS1_DATA, 32'h55);
      tick(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd0; RS1_ADDR = 5'd0; RS2_ADDR = 5'd0;
      tick(); ISSUE_EN = 1'b0;
      @(negedge CLK);
      chk("issue_x0_rs1", {31'd0, RS1_BUSY}, 32'd0);
      chk("issue_x0_rs2", {31'd0, RS2_BUSY}, 32'd0);

      // 4. simultaneous issue and writeback
      tick(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd9; WB_EN = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'hAA;
      tick(); ISSUE_EN = 1'b0; WB_EN = 1'b0; RS1_ADDR = 5'd9;
      @(negedge CLK);
      chk("same_edge_data", RS1_DATA, 32'hAA);
      chk("same_edge_busy", {31'd0, RS1_BUSY}, 32'd1);

      // 5. writeback to a busy register seen on a read port in the same cycle
      tick(); ISSUE_EN = 1'b1; ISSUE_RD = 5'd3;
      tick(); ISSUE_EN = 1'b0; WB_EN = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h77; RS2_ADDR = 5'd3;
      @(negedge CLK);
      chk("bypass_data", RS2_DATA, BYPASS ? 32'h77 : 32'h0);
      chk("bypass_busy", {31'd0, RS2_BUSY}, BYPASS ? 32'd0 : 32'd1);
      tick(); WB_EN = 1'b0;
      @(negedge CLK);
      chk("post_wb_x3_data", RS2_DATA, 32'h77);
      chk("post_wb_x3_busy", {31'd0, RS2_BUSY}, 32'd0);

      // randomized traffic with rare resets
      for (int n = 0; n < 3000; n++) begin
         tick();
         RESET    = ($urandom_range(0, 299) == 0);
         WB_EN    = $urandom_range(0, 1) == 1;
         WB_ADDR  = AW'($urandom);
         WB_DATA  = $urandom;
         ISSUE_EN = $urandom_range(0, 1) == 1;
         ISSUE_RD = AW'($urandom);
         RS1_ADDR = ($urandom_range(0, 3) == 0) ? WB_ADDR : AW'($urandom);
         RS2_ADDR = ($urandom_range(0, 3) == 0) ? ISSUE_RD : AW'($urandom);
      end
      tick(); RESET = 1'b0; WB_EN = 1'b0; ISSUE_EN = 1'b0;
      repeat (40) tick();

      // 6. mid-sweep reset and traffic during the sweep
      RESET = 1'b1;
      tick(); RESET = 1'b0;
      repeat (10) @(posedge CLK);
      #1; RESET = 1'b1;
      @(negedge CLK); chk("mid_sweep_ready", {31'd0, READY}, 32'd0);
      tick(); RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1; WB_EN = 1'b1; WB_ADDR = 5'd4; WB_DATA = 32'hFF; ISSUE_EN = 1'b1; ISSUE_RD = 5'd4;
      repeat (29) @(posedge CLK);
      @(negedge CLK); chk("resweep_ready_31", {31'd0, READY}, 32'd0);
      @(posedge CLK);
      #1; WB_EN = 1'b0; ISSUE_EN = 1'b0;
      @(negedge CLK); chk("resweep_ready_32", {31'd0, READY}, 32'd1);
      tick(); RS1_ADDR = 5'd4; RS2_ADDR = 5'd4;
      @(negedge CLK);
      chk("clear_traffic_data", RS1_DATA, 32'h0);
      chk("clear_traffic_busy", {31'd0, RS2_BUSY}, 32'd0);
      read_all_zero("resweep_zero");

      tick();
      chk_en = 1'b0;
      if (errors != 0) print_regs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
